miriscv_lsu_split: RTL

Parametrised load/store unit for the miriscv core. It replaces the single-cycle always-ready memory interface with a req/gnt/rvalid handshake that tolerates wait states. Accesses that straddle a DATA_W word boundary are split into two memory beats, with optional trapping instead. It sits between the core's LSU port and the data memory/bus.

---
 rtl/miriscv_lsu_split.sv | 208 ++++++++++++++++++++
 1 files changed

// File: rtl/miriscv_lsu_split.sv
// ==========================================================================
// miriscv_lsu_split : req/gnt/rvalid load/store unit with boundary splitting
// Revision: 1.0
// ==========================================================================
`default_nettype none

module miriscv_lsu_split #(
  parameter int DATA_W        = 32,
  parameter int ADDR_W        = 32,
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic                clk_i,
  input  logic                arstn_i,
  input  logic [ADDR_W-1:0]   lsu_addr_i,
  input  logic                lsu_we_i,
  input  logic [2:0]          lsu_size_i,
  input  logic [31:0]         lsu_data_i,
  input  logic                lsu_req_i,
  output logic                lsu_stall_req_o,
  output logic [31:0]         lsu_data_o,
  output logic                lsu_fault_o,
  output logic                data_req_o,
  input  logic                data_gnt_i,
  input  logic                data_rvalid_i,
  input  logic [DATA_W-1:0]   data_rdata_i,
  output logic                data_we_o,
  output logic [DATA_W/8-1:0] data_be_o,
  output logic [ADDR_W-1:0]   data_addr_o,
  output logic [DATA_W-1:0]   data_wdata_o
);

  localparam int BYTES = DATA_W / 8;
  localparam int OFF_W = $clog2(BYTES);
  localparam int SUM_W = OFF_W + 2;

  localparam logic [2:0] LDST_B  = 3'b000;
  localparam logic [2:0] LDST_H  = 3'b001;
  localparam logic [2:0] LDST_W  = 3'b010;
  localparam logic [2:0] LDST_BU = 3'b100;
  localparam logic [2:0] LDST_HU = 3'b101;

  localparam logic [ADDR_W-1:0] BYTES_A = ADDR_W'(BYTES);

  typedef logic [SUM_W-1:0]    sum_t;
  typedef logic [2*BYTES-1:0]  wbe_t;
  typedef logic [2*DATA_W-1:0] wwd_t;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    REQ0 = 3'd1,
    RSP0 = 3'd2,
    REQ1 = 3'd3,
    RSP1 = 3'd4,
    DONE = 3'd5
  } state_t;

  state_t state, state_next;

  logic [ADDR_W-1:0] addr_q;
  logic              we_q;
  logic [2:0]        size_q;
  logic [31:0]       wdata_q;
  logic              split_q;
  logic              fault_q;
  logic [DATA_W-1:0] beat0_q;
  logic [31:0]       lsu_data_q;

  // Byte mask of the access before it is shifted into lanes; zero for illegal sizes.
  function automatic logic [3:0] size_mask(input logic [2:0] size);
    case (size)
      LDST_B, LDST_BU: size_mask = 4'b0001;
      LDST_H, LDST_HU: size_mask = 4'b0011;
      LDST_W:          size_mask = 4'b1111;
      default:         size_mask = 4'b0000;
    endcase
  endfunction

  function automatic logic [3:0] size_nbytes(input logic [2:0] size);
    case (size)
      LDST_B, LDST_BU: size_nbytes = 4'd1;
      LDST_H, LDST_HU: size_nbytes = 4'd2;
      LDST_W:          size_nbytes = 4'd4;
      default:         size_nbytes = 4'd0;
    endcase
  endfunction

  function automatic logic is_split(input logic [OFF_W-1:0] off, input logic [2:0] size);
    sum_t sum;
    sum      = sum_t'(off) + sum_t'(size_nbytes(size));
    is_split = (sum > sum_t'(BYTES));
  endfunction

  function automatic logic [31:0] assemble(input wwd_t wide, input logic [OFF_W-1:0] off,
                                           input logic [2:0] size);
    logic [31:0] raw;
    raw = 32'(wide >> {off, 3'b000});
    case (size)
      LDST_B:  assemble = {{24{raw[7]}}, raw[7:0]};
      LDST_BU: assemble = {24'h0, raw[7:0]};
      LDST_H:  assemble = {{16{raw[15]}}, raw[15:0]};
      LDST_HU: assemble = {16'h0, raw[15:0]};
      default: assemble = raw;
    endcase
  endfunction

  logic [OFF_W-1:0]  off_in, off_q;
  logic              split_in, fault_in;
  logic [ADDR_W-1:0] beat0_addr, beat1_addr;
  wbe_t              wide_be;
  wwd_t              wide_wd;

  assign off_in     = lsu_addr_i[OFF_W-1:0];
  assign off_q      = addr_q[OFF_W-1:0];
  assign split_in   = is_split(off_in, lsu_size_i);
  assign fault_in   = (size_nbytes(lsu_size_i) == 4'd0) || (split_in && !MISALIGNED_EN);

  assign beat0_addr = {addr_q[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  assign beat1_addr = beat0_addr + BYTES_A;
  assign wide_be    = wbe_t'(size_mask(size_q)) << off_q;
  assign wide_wd    = wwd_t'(wdata_q) << {off_q, 3'b000};

  always_comb begin
    state_next   = state;
    data_req_o   = 1'b0;
    data_we_o    = 1'b0;
    data_be_o    = '0;
    data_addr_o  = '0;
    data_wdata_o = '0;
    case (state)
      IDLE: begin
        if (lsu_req_i) state_next = fault_in ? DONE : REQ0;
      end
      REQ0: begin
        data_req_o   = 1'b1;
        data_we_o    = we_q;
        data_be_o    = wide_be[BYTES-1:0];
        data_addr_o  = beat0_addr;
        data_wdata_o = wide_wd[DATA_W-1:0];
        if (data_gnt_i) begin
          if (!we_q)        state_next = RSP0;
          else if (split_q) state_next = REQ1;
          else              state_next = DONE;
        end
      end
      RSP0: begin
        if (data_rvalid_i) state_next = split_q ? REQ1 : DONE;
      end
      REQ1: begin
        data_req_o   = 1'b1;
        data_we_o    = we_q;
        data_be_o    = wide_be[2*BYTES-1:BYTES];
        data_addr_o  = beat1_addr;
        data_wdata_o = wide_wd[2*DATA_W-1:DATA_W];
        if (data_gnt_i) state_next = we_q ? DONE : RSP1;
      end
      RSP1: begin
        if (data_rvalid_i) state_next = DONE;
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!arstn_i) begin
      state      <= IDLE;
      addr_q     <= '0;
      we_q       <= 1'b0;
      size_q     <= 3'b000;
      wdata_q    <= '0;
      split_q    <= 1'b0;
      fault_q    <= 1'b0;
      beat0_q    <= '0;
      lsu_data_q <= '0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (lsu_req_i) begin
            addr_q  <= lsu_addr_i;
            we_q    <= lsu_we_i;
            size_q  <= lsu_size_i;
            wdata_q <= lsu_data_i;
            split_q <= split_in;
            fault_q <= fault_in;
          end
        end
        RSP0: begin
          if (data_rvalid_i) begin
            beat0_q <= data_rdata_i;
            if (!split_q) lsu_data_q <= assemble(wwd_t'(data_rdata_i), off_q, size_q);
          end
        end
        RSP1: begin
          if (data_rvalid_i) lsu_data_q <= assemble({data_rdata_i, beat0_q}, off_q, size_q);
        end
        default: ;
      endcase
    end
  end

  assign lsu_stall_req_o = lsu_req_i && (state != DONE);
  assign lsu_fault_o     = (state == DONE) && fault_q;
  assign lsu_data_o      = lsu_data_q;

endmodule

`default_nettype wire
